// File: rtl/i2s_track_scheduler_if.sv
// Track-source handshake bundle for i2s_track_scheduler.
//   trk_valid  : per-track sample available (source -> scheduler)
//   trk_ready  : per-track accept, one-hot or zero (scheduler -> source)
//   trk_data_l : packed left samples, track i at [i*WIDTH +: WIDTH]
//   trk_data_r : packed right samples, same packing
//   trk_mute   : per-track mute (source -> scheduler)
// Modports: master = track-source side, slave = scheduler side.
interface i2s_track_scheduler_if #(
  parameter int WIDTH      = 8,
  parameter int NUM_TRACKS = 4
);
  logic [NUM_TRACKS-1:0]       trk_valid;
  logic [NUM_TRACKS-1:0]       trk_ready;
  logic [NUM_TRACKS*WIDTH-1:0] trk_data_l;
  logic [NUM_TRACKS*WIDTH-1:0] trk_data_r;
  logic [NUM_TRACKS-1:0]       trk_mute;

  modport master (
    output trk_valid, trk_data_l, trk_data_r, trk_mute,
    input  trk_ready
  );

  modport slave (
    input  trk_valid, trk_data_l, trk_data_r, trk_mute,
    output trk_ready
  );
endinterface

// File: rtl/i2s_track_scheduler.sv
// Per-frame sample scheduler feeding an I2S transmitter.
// On each rising edge of ws it polls every track in order over a
// valid/ready handshake, sums the unmuted samples, saturates the sums to
// WIDTH bits and commits them to tx_data_l/tx_data_r.
// Ports:
//   mclk, rst_n   : clock, asynchronous active-low reset
//   ws            : transmitter word-select (mclk domain)
//   trk           : track handshake bundle (slave modport)
//   tx_data_l/r   : committed mix, held between commits
//   frame_strobe  : one-cycle pulse per commit
//   clip          : one-cycle pulse with frame_strobe if either channel saturated
//   underrun_cnt  : saturating count of track timeouts
module i2s_track_scheduler #(
  parameter int WIDTH      = 8,
  parameter int NUM_TRACKS = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                    mclk,
  input  logic                    rst_n,
  input  logic                    ws,
  i2s_track_scheduler_if.slave    trk,
  output logic [WIDTH-1:0]        tx_data_l,
  output logic [WIDTH-1:0]        tx_data_r,
  output logic                    frame_strobe,
  output logic                    clip,
  output logic [15:0]             underrun_cnt
);

  // Summing NUM_TRACKS samples needs $clog2(NUM_TRACKS) guard bits.
  localparam int ACC_W = WIDTH + $clog2(NUM_TRACKS);
  localparam int IDX_W = $clog2(NUM_TRACKS);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_TRACKS - 1);
  localparam logic [TMO_W-1:0]        LAST_TMO = TMO_W'(TIMEOUT - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX  = ACC_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN  = ACC_W'(-(2 ** (WIDTH - 1)));

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COMMIT
  } state_t;

  state_t                   state, state_next;
  logic                     ws_q;
  logic [IDX_W-1:0]         idx;
  logic [TMO_W-1:0]         tmo;
  logic signed [ACC_W-1:0]  acc_l, acc_r;

  logic                     ws_rise;
  logic                     take;
  logic                     expire;
  logic                     last;
  logic signed [WIDTH-1:0]  cur_l, cur_r;
  logic signed [ACC_W-1:0]  ext_l, ext_r;
  logic [WIDTH-1:0]         sat_l, sat_r;
  logic                     clip_l, clip_r;
  logic [NUM_TRACKS-1:0]    ready;

  // Only rising edges of ws start a frame; falling edges are ignored.
  assign ws_rise = ws & ~ws_q;

  // Current track's samples, sign-extended to accumulator width.
  always_comb begin
    cur_l = trk.trk_data_l[idx*WIDTH +: WIDTH];
    cur_r = trk.trk_data_r[idx*WIDTH +: WIDTH];
    ext_l = {{(ACC_W-WIDTH){cur_l[WIDTH-1]}}, cur_l};
    ext_r = {{(ACC_W-WIDTH){cur_r[WIDTH-1]}}, cur_r};
  end

  // A valid on the timeout cycle is a transfer, so expire excludes it.
  assign take   = (state == REQ) &&  trk.trk_valid[idx];
  assign expire = (state == REQ) && !trk.trk_valid[idx] && (tmo == LAST_TMO);
  assign last   = (idx == LAST_IDX);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    ready      = '0;
    unique case (state)
      IDLE: begin
        if (ws_rise) state_next = REQ;
      end
      REQ: begin
        ready[idx] = 1'b1;
        if ((take || expire) && last) state_next = COMMIT;
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // trk_ready is a pure decode of registered state and idx: it cannot glitch
  // from input activity and clears the instant reset asserts.
  assign trk.trk_ready = ready;

  // Signed saturation of the accumulators to WIDTH bits.
  always_comb begin
    sat_l  = acc_l[WIDTH-1:0];
    sat_r  = acc_r[WIDTH-1:0];
    clip_l = 1'b0;
    clip_r = 1'b0;
    if (acc_l > ACC_MAX) begin
      sat_l  = ACC_MAX[WIDTH-1:0];
      clip_l = 1'b1;
    end else if (acc_l < ACC_MIN) begin
      sat_l  = ACC_MIN[WIDTH-1:0];
      clip_l = 1'b1;
    end
    if (acc_r > ACC_MAX) begin
      sat_r  = ACC_MAX[WIDTH-1:0];
      clip_r = 1'b1;
    end else if (acc_r < ACC_MIN) begin
      sat_r  = ACC_MIN[WIDTH-1:0];
      clip_r = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q         <= 1'b0;
      idx          <= '0;
      tmo          <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      tx_data_l    <= '0;
      tx_data_r    <= '0;
      frame_strobe <= 1'b0;
      clip         <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      ws_q         <= ws;
      frame_strobe <= 1'b0;
      clip         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ws_rise) begin
            idx   <= '0;
            tmo   <= '0;
            acc_l <= '0;
            acc_r <= '0;
          end
        end
        REQ: begin
          if (take || expire) begin
            // Muted tracks are still consumed to keep sources frame-aligned.
            if (take && !trk.trk_mute[idx]) begin
              acc_l <= acc_l + ext_l;
              acc_r <= acc_r + ext_r;
            end
            if (expire && (underrun_cnt != 16'hFFFF)) begin
              underrun_cnt <= underrun_cnt + 16'd1;
            end
            tmo <= '0;
            if (!last) idx <= idx + 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        COMMIT: begin
          tx_data_l    <= sat_l;
          tx_data_r    <= sat_r;
          frame_strobe <= 1'b1;
          clip         <= clip_l | clip_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_track_scheduler.sv
// Directed self-checking bench for i2s_track_scheduler (WIDTH=8, 4 tracks,
// TIMEOUT=16). Inputs change 1 time unit after a rising mclk edge and
// outputs are sampled at that same point, away from the active edge.
module tb_i2s_track_scheduler;

  logic        mclk = 1'b0;
  logic        rst_n;
  logic        ws;
  logic [7:0]  tx_data_l, tx_data_r;
  logic        frame_strobe, clip;
  logic [15:0] underrun_cnt;

  int total = 0;
  int bad   = 0;

  logic [3:0] ready_log [0:63];
  int         strobe_cyc;
  int         cnt;
  logic       seen;

  i2s_track_scheduler_if #(.WIDTH(8), .NUM_TRACKS(4)) bus ();

  i2s_track_scheduler #(.WIDTH(8), .NUM_TRACKS(4), .TIMEOUT(16)) dut (
    .mclk         (mclk),
    .rst_n        (rst_n),
    .ws           (ws),
    .trk          (bus),
    .tx_data_l    (tx_data_l),
    .tx_data_r    (tx_data_r),
    .frame_strobe (frame_strobe),
    .clip         (clip),
    .underrun_cnt (underrun_cnt)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // Raises ws (that cycle is cycle 0), logs trk_ready per cycle and stops at
  // frame_strobe or after max_cyc cycles (strobe_cyc stays -1 then).
  // If late_cyc > 0, trk_valid[2] is raised during that cycle.
  task automatic run_frame(input int max_cyc, input int late_cyc);
    strobe_cyc = -1;
    for (int i = 0; i < 64; i++) ready_log[i] = 4'h0;
    ws = 1'b0;
    step();
    step();
    ws = 1'b1;
    for (int k = 1; k <= max_cyc; k++) begin
      step();
      if (k < 64) ready_log[k] = bus.trk_ready;
      if (frame_strobe) begin
        strobe_cyc = k;
        break;
      end
      if (k == late_cyc) bus.trk_valid[2] = 1'b1;
    end
  endtask

  initial begin
    // ---------------- reset with random inputs ----------------
    rst_n          = 1'b0;
    ws             = 1'($urandom);
    bus.trk_valid  = 4'($urandom);
    bus.trk_mute   = 4'($urandom);
    bus.trk_data_l = 32'($urandom);
    bus.trk_data_r = 32'($urandom);
    step();
    step();
    check("rst_ready", 32'(bus.trk_ready), 32'h0);
    check("rst_tx_l", 32'(tx_data_l), 32'h0);
    check("rst_tx_r", 32'(tx_data_r), 32'h0);
    check("rst_strobe", 32'(frame_strobe), 32'h0);
    check("rst_clip", 32'(clip), 32'h0);
    check("rst_underrun", 32'(underrun_cnt), 32'h0);

    // Release with ws static low: nothing may happen.
    ws = 1'b0;
    bus.trk_valid  = 4'hF;
    bus.trk_mute   = 4'h0;
    bus.trk_data_l = {8'sd7, -8'sd5, 8'sd20, 8'sd10};
    bus.trk_data_r = {8'd4, 8'd3, 8'd2, 8'd1};
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (frame_strobe || bus.trk_ready != 4'h0) seen = 1'b1;
    end
    check("idle_after_rst", 32'(seen), 32'h0);

    // ---------------- nominal mix ----------------
    run_frame(40, 0);
    check("nom_ready1", 32'(ready_log[1]), 32'h1);
    check("nom_ready2", 32'(ready_log[2]), 32'h2);
    check("nom_ready3", 32'(ready_log[3]), 32'h4);
    check("nom_ready4", 32'(ready_log[4]), 32'h8);
    check("nom_strobe_cyc", 32'(strobe_cyc), 32'd6);
    check("nom_tx_l", 32'(tx_data_l), 32'd32);
    check("nom_tx_r", 32'(tx_data_r), 32'd10);
    check("nom_clip", 32'(clip), 32'h0);
    step();
    check("nom_strobe_width", 32'(frame_strobe), 32'h0);
    check("nom_hold_l", 32'(tx_data_l), 32'd32);

    // A falling edge of ws alone must not start a fetch.
    step();
    ws = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (frame_strobe || bus.trk_ready != 4'h0) seen = 1'b1;
    end
    check("fall_no_fetch", 32'(seen), 32'h0);

    // ---------------- saturation ----------------
    bus.trk_data_l = {4{8'd100}};
    bus.trk_data_r = {4{8'h9C}};
    run_frame(40, 0);
    check("sat_strobe_cyc", 32'(strobe_cyc), 32'd6);
    check("sat_tx_l", 32'(tx_data_l), 32'h7F);
    check("sat_tx_r", 32'(tx_data_r), 32'h80);
    check("sat_clip", 32'(clip), 32'h1);
    step();
    check("sat_clip_width", 32'(clip), 32'h0);

    // ---------------- mute track 1 ----------------
    bus.trk_data_l = {8'sd7, -8'sd5, 8'sd20, 8'sd10};
    bus.trk_data_r = {8'd4, 8'd3, 8'd2, 8'd1};
    bus.trk_mute   = 4'b0010;
    run_frame(40, 0);
    check("mute_ready1", 32'(ready_log[2]), 32'h2);
    check("mute_strobe_cyc", 32'(strobe_cyc), 32'd6);
    check("mute_tx_l", 32'(tx_data_l), 32'd12);
    check("mute_tx_r", 32'(tx_data_r), 32'd8);
    bus.trk_mute = 4'h0;

    // ---------------- underrun on track 2 ----------------
    bus.trk_valid = 4'b1011;
    run_frame(60, 0);
    cnt = 0;
    for (int k = 1; k < 64; k++) if (ready_log[k] == 4'b0100) cnt++;
    check("udr_ready2_cycles", 32'(cnt), 32'd16);
    check("udr_strobe_cyc", 32'(strobe_cyc), 32'd21);
    check("udr_count", 32'(underrun_cnt), 32'd1);
    check("udr_tx_l", 32'(tx_data_l), 32'd37);
    check("udr_tx_r", 32'(tx_data_r), 32'd7);

    // Valid arriving on the 16th waiting cycle wins over the timeout.
    bus.trk_valid = 4'b1011;
    run_frame(60, 18);
    check("late_strobe_cyc", 32'(strobe_cyc), 32'd21);
    check("late_count", 32'(underrun_cnt), 32'd1);
    check("late_tx_l", 32'(tx_data_l), 32'd32);
    check("late_tx_r", 32'(tx_data_r), 32'd10);
    bus.trk_valid = 4'hF;

    // ---------------- reset mid-operation ----------------
    ws = 1'b0;
    step();
    step();
    ws = 1'b1;
    step();
    step();
    check("mid_ready_idx1", 32'(bus.trk_ready), 32'h2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.trk_ready), 32'h0);
    check("mid_rst_tx_l", 32'(tx_data_l), 32'h0);
    check("mid_rst_tx_r", 32'(tx_data_r), 32'h0);
    check("mid_rst_underrun", 32'(underrun_cnt), 32'h0);
    ws = 1'b0;
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (frame_strobe || bus.trk_ready != 4'h0) seen = 1'b1;
    end
    check("mid_idle_after", 32'(seen), 32'h0);
    run_frame(40, 0);
    check("mid_strobe_cyc", 32'(strobe_cyc), 32'd6);
    check("mid_tx_l", 32'(tx_data_l), 32'd32);
    check("mid_tx_r", 32'(tx_data_r), 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_track_scheduler.md
# i2s_track_scheduler

Per-frame sample scheduler that sits upstream of the I2S transmitter in the DAW output path. It watches the transmitter's word-select clock, and once per stereo frame it polls each track source in turn over a valid/ready handshake. It mixes the collected samples with signed saturation and commits the result to the stable `tx_data_l`/`tx_data_r` registers that the transmitter latches.

## Interface

Parameters:
- `WIDTH`, 8, sample width in bits; two's-complement signed; matches the transmitter.
- `NUM_TRACKS`, 4, number of track sources polled per frame; must be ≥ 2.
- `TIMEOUT`, 16, mclk cycles a track may hold `trk_valid` low before an underrun is declared.
- Constraint: `NUM_TRACKS*TIMEOUT + 2` must be less than the half-frame length in mclk cycles (128 at default transmitter settings).

Ports:
- `mclk`  in  1  main clock; the single clock of the block.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ws`  in  1  word-select from the transmitter, same `mclk` domain.
- `trk_valid`  in  NUM_TRACKS  per-track sample available.
- `trk_ready`  out  NUM_TRACKS  per-track sample accept; at most one bit set.
- `trk_data_l`  in  NUM_TRACKS*WIDTH  left samples; track i at `[i*WIDTH +: WIDTH]`.
- `trk_data_r`  in  NUM_TRACKS*WIDTH  right samples, same packing.
- `trk_mute`  in  NUM_TRACKS  per-track mute.
- `tx_data_l`  out  WIDTH  mixed left sample to the transmitter.
- `tx_data_r`  out  WIDTH  mixed right sample to the transmitter.
- `frame_strobe`  out  1  one-cycle pulse when a new mix is committed.
- `clip`  out  1  one-cycle pulse, coincident with `frame_strobe`, when L or R saturated.
- `underrun_cnt`  out  16  total track timeouts since reset; saturates at 0xFFFF.

## Operation

- Reset (`rst_n` low, async):
  - All outputs go to 0, including `trk_ready`.
  - `ws_q` clears to 0.
  - State goes to IDLE; accumulators and counters clear.
- Edge detect: `ws_q` is the registered copy of `ws`. A rising edge is `ws==1 && ws_q==0`. Falling edges are ignored.
- Timing relationship: right data is latched by the transmitter at the rising edge, so committing before the next falling edge delivers the new L, then the new R.
- FSM states: IDLE, REQ, COMMIT.
- IDLE:
  - On a rising edge, go to REQ with `idx=0`, `acc_l=acc_r=0` and `tmo=0`.
- REQ:
  - `trk_ready = 1<<idx`.
  - If `trk_valid[idx]` is high, the transfer completes this cycle:
    - If `trk_mute[idx]` is low, add the sign-extended L/R to the accumulators.
    - A muted track is still consumed, so it stays time-aligned.
    - Clear `tmo`.
  - Else, if `tmo==TIMEOUT-1`, declare an underrun:
    - The track contributes 0.
    - `underrun_cnt` increments (saturating).
    - Clear `tmo`.
  - Else, `tmo` increments and the block stays on the same `idx`.
  - After a transfer or an underrun: if `idx==NUM_TRACKS-1`, go to COMMIT; otherwise increment `idx`.
  - A valid that arrives on the timeout cycle wins; it is treated as a transfer, not an underrun.
- COMMIT:
  - Saturate each accumulator to the range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Register the results into `tx_data_l`/`tx_data_r`.
  - Pulse `frame_strobe`; pulse `clip` if either channel saturated.
  - Go to IDLE.
- Accumulator width is `WIDTH + $clog2(NUM_TRACKS)`, signed; the sum cannot overflow.
- A rising edge of `ws` seen outside IDLE is ignored. `tx_data_*` hold their last committed values until the next COMMIT.

## Timing

- Cycle 0 is the first cycle in which `ws` reads 1 after reading 0.
- REQ is entered at cycle 1.
- With every `trk_valid` high, each track takes 1 cycle. New `tx_data_*` and `frame_strobe` become visible at cycle `NUM_TRACKS+2` (cycle 6 at defaults).
- Each underrunning track adds `TIMEOUT-1` cycles.
- Each cycle of delayed valid adds 1 cycle.
- `trk_ready` is registered-state-decoded: it is high only in REQ, for the current `idx`. It drops in the cycle after the transfer.
- Outputs are updated only from the COMMIT transition and are never glitched between commits.

## Test plan

- Reset: hold `rst_n` low with random inputs -> all outputs 0 and `trk_ready=0`. Release with `ws` static -> no `frame_strobe`.
- Nominal mix (WIDTH=8, N=4): L = 10, 20, -5, 7 and R = 1, 2, 3, 4, all valid. Raise `ws` -> `trk_ready` sequence 0001, 0010, 0100, 1000, then `tx_data_l=32`, `tx_data_r=10`, with `frame_strobe` for 1 cycle at cycle 6 and `clip=0`.
- Saturation: all L=100, all R=-100 -> `tx_data_l=127`, `tx_data_r=-128`, `clip` pulses with `frame_strobe`.
- Mute: nominal values with `trk_mute=0010` -> track 1 is still handshaken (`trk_ready[1]` pulses); result `tx_data_l=12`, `tx_data_r=8`.
- Underrun: track 2 `trk_valid` stuck low, others valid -> `trk_ready[2]` high for 16 cycles, `underrun_cnt` goes 0->1, track 2 contributes 0, `frame_strobe` at cycle 21. A second run with valid arriving on the 16th cycle -> transfer and no increment.
- Reset mid-operation: assert `rst_n` low while in REQ at `idx=1` -> `trk_ready` and all outputs 0 immediately. After release, no activity until the next `ws` rising edge, then a normal commit. A `ws` falling edge alone never starts a fetch.
